// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with sync, blanking and start strobes.
// Define VGA_PIX_DIV2_EN to advance the counters on every second clk cycle instead of every cycle.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pix_tick,
    output logic        line_start,
    output logic        frame_start
);
    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        advance;
    logic        x_wrap;
    logic        y_wrap;
    logic [10:0] next_x;
    logic [10:0] next_y;

`ifdef VGA_PIX_DIV2_EN
    logic phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 1'b0;
        else        phase <= ~phase;
    end

    assign advance = phase;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        x_wrap = (pix_x == H_LAST);
        y_wrap = (pix_y == V_LAST);
        next_x = x_wrap ? '0 : pix_x + 11'd1;
        next_y = pix_y;
        if (x_wrap) next_y = y_wrap ? '0 : pix_y + 11'd1;
    end

    // Sync/blank flags are registered from the next counter values so they change on the same edge as the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x       <= H_LAST;
            pix_y       <= V_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_tick    <= advance;
            line_start  <= advance && x_wrap;
            frame_start <= advance && x_wrap && y_wrap;
            if (advance) begin
                pix_x    <= next_x;
                pix_y    <= next_y;
                hsync    <= !(next_x >= HS_BEGIN && next_x < HS_END);
                vsync    <= !(next_y >= VS_BEGIN && next_y < VS_END);
                video_on <= (next_x < H_VIS) && (next_y < V_VIS);
            end
        end
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL be the number of visible pixels per line.
REQ-002 Parameter H_FP, default 16, SHALL be the horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, SHALL be the hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, SHALL be the horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, SHALL be the number of visible lines per frame.
REQ-006 Parameter V_FP, default 10, SHALL be the vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, SHALL be the vsync pulse width in lines.
REQ-008 Parameter V_BP, default 33, SHALL be the vertical back porch in lines.
REQ-009 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-010 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-011 Port pix_x, output, 11 bits, SHALL be the current horizontal pixel count, feeding sprite renderers.
REQ-012 Port pix_y, output, 11 bits, SHALL be the current line count, feeding sprite renderers.
REQ-013 Port hsync, output, 1 bit, SHALL be horizontal sync, active low.
REQ-014 Port vsync, output, 1 bit, SHALL be vertical sync, active low.
REQ-015 Port video_on, output, 1 bit, SHALL be high only when pix_x < H_ACTIVE and pix_y < V_ACTIVE.
REQ-016 Port pix_tick, output, 1 bit, SHALL pulse high in each clk cycle in which the counters advance.
REQ-017 Port line_start, output, 1 bit, SHALL be high for one clk cycle when pix_x becomes 0.
REQ-018 Port frame_start, output, 1 bit, SHALL be high for one clk cycle when (pix_x, pix_y) becomes (0, 0).

Function
REQ-019 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-020 On each pix_tick, pix_x SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-021 pix_y SHALL increment only on the pix_tick where pix_x wraps, wrapping from V_TOTAL-1 to 0.
REQ-022 pix_x and pix_y SHALL be registered counter values and SHALL hold between ticks.
REQ-023 hsync SHALL be low exactly while H_ACTIVE+H_FP <= pix_x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
REQ-024 vsync SHALL be low exactly while V_ACTIVE+V_FP <= pix_y < V_ACTIVE+V_FP+V_SYNC (default 490..491).
REQ-025 hsync, vsync and video_on SHALL be aligned with pix_x/pix_y in the same clk cycle, with zero cycles of skew.
REQ-026 line_start and frame_start SHALL assert in the same cycle as the new counter value and SHALL deassert in the next clk cycle.
REQ-027 At a frame wrap (799,524)->(0,0), line_start and frame_start SHALL both assert in the same cycle.
REQ-028 Counter arithmetic SHALL be 11-bit unsigned; parameters giving a total above 2047 are unsupported.

Reset
REQ-029 While rst_n is low, pix_x SHALL be H_TOTAL-1 and pix_y SHALL be V_TOTAL-1.
REQ-030 While rst_n is low, hsync=1, vsync=1, video_on=0, pix_tick=0, line_start=0 and frame_start=0.
REQ-031 The first pix_tick after rst_n deasserts SHALL move the counters to (0,0) and assert frame_start.
REQ-032 Reset asserted mid-frame SHALL immediately force the REQ-029/030 values, independent of clk.

Configuration
REQ-033 With macro VGA_PIX_DIV2_EN defined, an internal toggle SHALL make pix_tick high on every second clk cycle, with the first tick on the second clk edge after reset release.
REQ-034 Without VGA_PIX_DIV2_EN, pix_tick SHALL be high on every clk cycle after reset release.

Verification
REQ-035 Reset release, macro off, defaults -> frame_start=1 with pix_x=0, pix_y=0, video_on=1 on the first clk edge.
REQ-036 Run one line, macro off -> hsync low for exactly 96 cycles starting at pix_x=656, and line period = 800 cycles.
REQ-037 Run one frame, macro off -> vsync low for lines 490-491 only, frame period = 420000 cycles, and exactly one frame_start.
REQ-038 Sweep pix_x 639->640 and pix_y 479->480 -> video_on falls in the same cycle as the count change.
REQ-039 Macro on -> pix_tick on alternate cycles, counters hold on non-tick cycles, and frame period = 840000 clk.
REQ-040 Assert rst_n low at pix_x=300, pix_y=200 between clk edges -> outputs take the reset values without waiting for a clk edge.
